// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizes and deglitches ps2c, shifts in an 11-bit frame,
// checks odd parity and the stop bit, and discards frames that stall past a watchdog limit.
module ps2_rx_frame #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       CLK,
    input  logic       reset_n,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       err_tick
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK} state_t;

    logic [1:0]    c_sync_q, d_sync_q;
    logic          c_s, d_s;
    logic          fc_q, fc_d;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic          fall;

    state_t        state_q, state_d;
    logic [3:0]    n_q, n_d;
    logic [8:0]    sr_q, sr_d;
    logic [WW-1:0] wd_q, wd_d;
    logic [7:0]    dout_q, dout_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [9:0]    frame;

    assign c_s = c_sync_q[1];
    assign d_s = d_sync_q[1];

    always_comb begin
        fc_d      = fc_q;
        flt_cnt_d = '0;
        fall      = 1'b0;
        if (c_s != fc_q) begin
            if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
                fc_d = c_s;
                fall = fc_q;
            end else begin
                flt_cnt_d = flt_cnt_q + 1'b1;
            end
        end
    end

    // The final fall carries the stop bit, so the frame is judged here and the
    // registered pulse lands in the one-cycle CHECK state.
    assign frame = {d_s, sr_q};

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        sr_d    = sr_q;
        wd_d    = '0;
        dout_d  = dout_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fall && rx_en && !d_s) begin
                    state_d = S_SHIFT;
                    n_d     = 4'd9;
                end
            end
            S_SHIFT: begin
                if (fall) begin
                    sr_d = {d_s, sr_q[8:1]};
                    if (n_q == 4'd0) begin
                        state_d = S_CHECK;
                        if (frame[9] && (^frame[8:0])) begin
                            dout_d = frame[7:0];
                            done_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        n_d = n_q - 1'b1;
                    end
                end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_CHECK: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            c_sync_q  <= 2'b11;
            d_sync_q  <= 2'b11;
            fc_q      <= 1'b1;
            flt_cnt_q <= '0;
            state_q   <= S_IDLE;
            n_q       <= '0;
            sr_q      <= '0;
            wd_q      <= '0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            c_sync_q  <= {c_sync_q[0], ps2c};
            d_sync_q  <= {d_sync_q[0], ps2d};
            fc_q      <= fc_d;
            flt_cnt_q <= flt_cnt_d;
            state_q   <= state_d;
            n_q       <= n_d;
            sr_q      <= sr_d;
            wd_q      <= wd_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign err_tick     = err_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Bench for ps2_rx_frame: drives PS/2 frames at a scaled-down bus rate and
// compares outcomes with a parity/stop-bit model of the frame format.
module tb_ps2_rx_frame;

    localparam int FL = 4;
    localparam int TO = 400;
    localparam int HP = 30;

    logic       CLK = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic       rx_en = 1'b1;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       err_tick;

    ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .reset_n(reset_n), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
        .dout(dout), .rx_done_tick(rx_done_tick), .err_tick(err_tick)
    );

    always #10 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    int checks = 0;
    int failures = 0;
    int n_done = 0;
    int n_err = 0;
    int err_cyc = 0;
    int overlap = 0;
    int last_fall_cyc = 0;
    logic [7:0] tick_dout = 8'h00;
    logic [7:0] exp_dout = 8'h00;

    always @(negedge CLK) begin
        if (rx_done_tick) begin
            n_done++;
            tick_dout = dout;
        end
        if (err_tick) begin
            n_err++;
            err_cyc = cyc;
        end
        if (rx_done_tick && err_tick) overlap++;
    end

    function automatic logic odd_par(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    function automatic bit frame_good(input logic [7:0] d, input logic par, input logic stop);
        return stop && ((($countones(d) + int'(par)) % 2) == 1);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_bits(input logic [7:0] data, input logic par, input logic stop,
                             input int nbits, input int glitch_bit, input int drop_bit);
        logic [10:0] fr;
        fr = {stop, par, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = fr[i];
            if (i == drop_bit) rx_en = 1'b0;
            if (i == glitch_bit) begin
                idle(8);
                ps2c = 1'b0;
                idle(FL - 1);
                ps2c = 1'b1;
                idle(HP - 8 - (FL - 1));
            end else begin
                idle(HP);
            end
            ps2c = 1'b0;
            last_fall_cyc = cyc;
            idle(HP);
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                              input int glitch_bit, input int drop_bit,
                              output int dd, output int de);
        int d0, e0;
        d0 = n_done;
        e0 = n_err;
        send_bits(data, par, stop, 11, glitch_bit, drop_bit);
        idle(40);
        dd = n_done - d0;
        de = n_err - e0;
        if (frame_good(data, par, stop) && rx_en) exp_dout = data;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        idle(5);
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout: got %h expected 00", dout); end
        checks++; if (rx_done_tick !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", rx_done_tick); end
        checks++; if (err_tick !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err_tick); end
        reset_n = 1'b1;
        exp_dout = 8'h00;
        idle(20);
    endtask

    task automatic test_basic;
        int dd, de;
        send_frame(8'h1C, 1'b0, 1'b1, -1, -1, dd, de);
        checks++; if (dd !== 1) begin failures++; $display("FAIL basic_ticks: got %0d expected 1", dd); end
        checks++; if (de !== 0) begin failures++; $display("FAIL basic_err: got %0d expected 0", de); end
        checks++; if (tick_dout !== 8'h1C) begin failures++; $display("FAIL basic_tick_dout: got %h expected 1c", tick_dout); end
        checks++; if (dout !== 8'h1C) begin failures++; $display("FAIL basic_dout: got %h expected 1c", dout); end
    endtask

    task automatic test_back_to_back;
        int dd, de;
        send_frame(8'hF0, 1'b1, 1'b1, -1, -1, dd, de);
        checks++; if (dd !== 1 || tick_dout !== 8'hF0) begin failures++; $display("FAIL b2b_first: ticks %0d dout %h expected 1 f0", dd, tick_dout); end
        idle(60);
        send_frame(8'h16, 1'b0, 1'b1, -1, -1, dd, de);
        checks++; if (dd !== 1 || tick_dout !== 8'h16) begin failures++; $display("FAIL b2b_second: ticks %0d dout %h expected 1 16", dd, tick_dout); end
        checks++; if (de !== 0) begin failures++; $display("FAIL b2b_err: got %0d expected 0", de); end
    endtask

    task automatic test_parity_err;
        int dd, de;
        send_frame(8'h16, 1'b1, 1'b1, -1, -1, dd, de);
        checks++; if (de !== 1) begin failures++; $display("FAIL parity_err: got %0d expected 1", de); end
        checks++; if (dd !== 0) begin failures++; $display("FAIL parity_ticks: got %0d expected 0", dd); end
        checks++; if (dout !== exp_dout) begin failures++; $display("FAIL parity_dout: got %h expected %h", dout, exp_dout); end
    endtask

    task automatic test_framing_err;
        int dd, de;
        send_frame(8'h45, 1'b0, 1'b0, -1, -1, dd, de);
        checks++; if (de !== 1 || dd !== 0) begin failures++; $display("FAIL framing_err: err %0d ticks %0d expected 1 0", de, dd); end
        checks++; if (dout !== exp_dout) begin failures++; $display("FAIL framing_dout: got %h expected %h", dout, exp_dout); end
        send_frame(8'h45, 1'b0, 1'b1, -1, -1, dd, de);
        checks++; if (dd !== 1 || de !== 0 || dout !== 8'h45) begin failures++; $display("FAIL framing_recover: ticks %0d err %0d dout %h expected 1 0 45", dd, de, dout); end
    endtask

    task automatic test_timeout;
        int dd, de, d0, e0, exp_cyc;
        logic [7:0] keep;
        keep = exp_dout;
        d0 = n_done;
        e0 = n_err;
        send_bits(8'h5A, 1'b1, 1'b1, 5, -1, -1);
        idle(TO + FL + 40);
        exp_cyc = last_fall_cyc + FL + 2 + TO;
        checks++; if (n_err - e0 !== 1) begin failures++; $display("FAIL timeout_err: got %0d expected 1", n_err - e0); end
        checks++; if (err_cyc < exp_cyc - 2 || err_cyc > exp_cyc + 2) begin failures++; $display("FAIL timeout_cycle: got %0d expected %0d", err_cyc, exp_cyc); end
        checks++; if (n_done - d0 !== 0 || dout !== keep) begin failures++; $display("FAIL timeout_dout: ticks %0d dout %h expected 0 %h", n_done - d0, dout, keep); end
        send_frame(8'h5A, 1'b1, 1'b1, -1, -1, dd, de);
        checks++; if (dd !== 1 || de !== 0 || dout !== 8'h5A) begin failures++; $display("FAIL timeout_recover: ticks %0d err %0d dout %h expected 1 0 5a", dd, de, dout); end
    endtask

    task automatic test_glitch;
        int dd, de, d0, e0;
        d0 = n_done;
        e0 = n_err;
        ps2d = 1'b0;
        idle(5);
        ps2c = 1'b0;
        idle(FL - 1);
        ps2c = 1'b1;
        idle(20);
        ps2d = 1'b1;
        idle(20);
        checks++; if (n_done - d0 !== 0 || n_err - e0 !== 0) begin failures++; $display("FAIL glitch_idle: ticks %0d err %0d expected 0 0", n_done - d0, n_err - e0); end
        send_frame(8'h3B, odd_par(8'h3B), 1'b1, 3, -1, dd, de);
        checks++; if (dd !== 1 || de !== 0 || dout !== 8'h3B) begin failures++; $display("FAIL glitch_frame: ticks %0d err %0d dout %h expected 1 0 3b", dd, de, dout); end
    endtask

    task automatic test_rx_en;
        int dd, de;
        rx_en = 1'b0;
        send_frame(8'h29, odd_par(8'h29), 1'b1, -1, -1, dd, de);
        checks++; if (dd !== 0 || de !== 0 || dout !== exp_dout) begin failures++; $display("FAIL rx_en_low: ticks %0d err %0d dout %h expected 0 0 %h", dd, de, dout, exp_dout); end
        rx_en = 1'b1;
        idle(20);
        send_frame(8'hA7, odd_par(8'hA7), 1'b1, -1, 2, dd, de);
        exp_dout = 8'hA7;
        rx_en = 1'b1;
        checks++; if (dd !== 1 || de !== 0 || dout !== 8'hA7) begin failures++; $display("FAIL rx_en_midframe: ticks %0d err %0d dout %h expected 1 0 a7", dd, de, dout); end
    endtask

    task automatic test_reset_midframe;
        int dd, de;
        send_bits(8'h77, 1'b0, 1'b1, 4, -1, -1);
        @(negedge CLK);
        reset_n = 1'b0;
        #1;
        checks++; if (dout !== 8'h00 || rx_done_tick !== 1'b0 || err_tick !== 1'b0) begin failures++; $display("FAIL reset_mid: dout %h done %b err %b expected 00 0 0", dout, rx_done_tick, err_tick); end
        exp_dout = 8'h00;
        idle(5);
        reset_n = 1'b1;
        idle(20);
        send_frame(8'h77, odd_par(8'h77), 1'b1, -1, -1, dd, de);
        checks++; if (dd !== 1 || de !== 0 || dout !== 8'h77) begin failures++; $display("FAIL reset_mid_recover: ticks %0d err %0d dout %h expected 1 0 77", dd, de, dout); end
    endtask

    task automatic test_random;
        int dd, de, kind;
        logic [7:0] data;
        logic par, stop;
        bit good;
        for (int i = 0; i < 8; i++) begin
            data = 8'($urandom);
            kind = $urandom_range(0, 3);
            par  = (kind == 0) ? ~odd_par(data) : odd_par(data);
            stop = (kind == 1) ? 1'b0 : 1'b1;
            good = frame_good(data, par, stop);
            send_frame(data, par, stop, -1, -1, dd, de);
            checks++; if (dd !== (good ? 1 : 0) || de !== (good ? 0 : 1)) begin failures++; $display("FAIL random_pulses[%0d]: data %h ticks %0d err %0d good %0d", i, data, dd, de, good); end
            checks++; if (dout !== exp_dout) begin failures++; $display("FAIL random_dout[%0d]: got %h expected %h", i, dout, exp_dout); end
            idle($urandom_range(10, 80));
        end
        checks++; if (overlap !== 0) begin failures++; $display("FAIL tick_overlap: got %0d expected 0", overlap); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_parity_err();
        test_framing_err();
        test_timeout();
        test_glitch();
        test_rx_en();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
